// File: rtl/mac4_col.sv
// mac4_col: four-lane multiply-accumulate column stage.
// Accepts four unsigned samples per column. Each sample is multiplied by one
// coefficient slice C[*][k], and the product is accumulated per lane. The
// finished column is then presented on MU1..MU4 with a one-cycle web pulse.
module mac4_col #(
   parameter int DW = 8,
   parameter int CW = 7,
   parameter int RW = DW + CW + 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic [1:0]      coef_k,
   input  logic [4*CW-1:0] coef_data,
   input  logic            wb_busy,
   output logic            web,
   output logic [RW-1:0]   MU1,
   output logic [RW-1:0]   MU2,
   output logic [RW-1:0]   MU3,
   output logic [RW-1:0]   MU4,
   output logic            frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

   state_t        state_q, state_d;
   logic [1:0]    k_q, k_d;
   logic [1:0]    col_q, col_d;
   logic [RW-1:0] acc_q [4];
   logic [RW-1:0] acc_d [4];
   logic [RW-1:0] mu_q  [4];
   logic [RW-1:0] mu_d  [4];
   logic          web_q, web_d;
   logic          fd_q, fd_d;
   logic          accept;

   // Unsigned product zero-extended to the result width. The four-term sum
   // cannot exceed 4*255*127, so no saturation is needed.
   function automatic logic [RW-1:0] lane_prod(input logic [DW-1:0] x,
                                                input logic [CW-1:0] c);
      logic [DW+CW-1:0] p;
      p = {{CW{1'b0}}, x} * {{DW{1'b0}}, c};
      return {{(RW-DW-CW){1'b0}}, p};
   endfunction

   assign in_ready   = (state_q != S_OUT);
   assign coef_k     = (state_q == S_IDLE) ? 2'd0 : k_q;
   assign accept     = in_valid & in_ready;
   assign web        = web_q;
   assign frame_done = fd_q;
   assign MU1        = mu_q[0];
   assign MU2        = mu_q[1];
   assign MU3        = mu_q[2];
   assign MU4        = mu_q[3];

   // Next-state logic: accumulate in IDLE/ACC, emit the column from OUT.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      col_d   = col_q;
      web_d   = 1'b0;
      fd_d    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         acc_d[i] = acc_q[i];
         mu_d[i]  = mu_q[i];
      end
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               for (int i = 0; i < 4; i++)
                  acc_d[i] = lane_prod(in_data, coef_data[CW*i +: CW]);
               k_d     = 2'd1;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            if (accept) begin
               for (int i = 0; i < 4; i++)
                  acc_d[i] = acc_q[i] + lane_prod(in_data, coef_data[CW*i +: CW]);
               k_d = k_q + 2'd1;
               if (k_q == 2'd3)
                  state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (!wb_busy) begin
               for (int i = 0; i < 4; i++)
                  mu_d[i] = acc_q[i];
               web_d   = 1'b1;
               fd_d    = (col_q == 2'd3);
               col_d   = col_q + 2'd1;
               k_d     = 2'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            k_d     = 2'd0;
         end
      endcase
   end

   // State registers; reset also clears the datapath so no partial column survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= 2'd0;
         col_q   <= 2'd0;
         web_q   <= 1'b0;
         fd_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            acc_q[i] <= '0;
            mu_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         col_q   <= col_d;
         web_q   <= web_d;
         fd_q    <= fd_d;
         for (int i = 0; i < 4; i++) begin
            acc_q[i] <= acc_d[i];
            mu_q[i]  <= mu_d[i];
         end
      end
   end

endmodule
